// File: rtl/writeback_stage_if.sv
// Handshake and register-file write bundle between the memory stage, the data-memory
// response path and the writeback stage.
interface writeback_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_rd;
  logic [1:0]      i_wb_sel;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_alu_result;
  logic [XLEN-1:0] i_pc;
  logic            i_mem_rvalid;
  logic [XLEN-1:0] i_mem_rdata;
  logic            o_write_enable;
  logic [4:0]      o_rd_addr;
  logic [XLEN-1:0] o_write_data;
  logic            o_retire;
  logic            o_fault;

  modport master (
    output i_valid, i_rd, i_wb_sel, i_funct3, i_alu_result, i_pc, i_mem_rvalid, i_mem_rdata,
    input  o_ready, o_write_enable, o_rd_addr, o_write_data, o_retire, o_fault
  );

  modport slave (
    input  i_valid, i_rd, i_wb_sel, i_funct3, i_alu_result, i_pc, i_mem_rvalid, i_mem_rdata,
    output o_ready, o_write_enable, o_rd_addr, o_write_data, o_retire, o_fault
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects ALU / load / link result, waits for load data, extracts and
// extends the addressed byte or halfword, and drives the register-file write port.
module writeback_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  writeback_stage_if.slave  wb
);

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbLoad = 2'd1;
  localparam logic [1:0] WbLink = 2'd2;
  localparam logic [1:0] WbNone = 2'd3;

  typedef enum logic [1:0] {StIdle, StWaitMem, StCommit} state_e;

  state_e          state_q, state_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [2:0]      ld_funct3_q, ld_funct3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            ld_fault_q, ld_fault_d;
  logic            we_q, we_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            retire_q, retire_d;
  logic            fault_q, fault_d;

  logic            ready;
  logic            accept;
  logic            in_illegal;
  logic            in_misaligned;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] direct_data;

  assign ready  = (state_q != StWaitMem);
  assign accept = wb.i_valid && ready;

  always_comb begin
    in_illegal    = (wb.i_funct3 == 3'd3) || (wb.i_funct3 == 3'd6) || (wb.i_funct3 == 3'd7);
    in_misaligned = 1'b0;
    if ((wb.i_funct3 == 3'd1) || (wb.i_funct3 == 3'd5)) begin
      in_misaligned = wb.i_alu_result[0];
    end else if (wb.i_funct3 == 3'd2) begin
      in_misaligned = (wb.i_alu_result[1:0] != 2'b00);
    end
  end

  // Memory returns the aligned word; the latched offset picks the lane.
  always_comb begin
    byte_sel = wb.i_mem_rdata[{ld_off_q, 3'b000} +: 8];
    half_sel = ld_off_q[1] ? wb.i_mem_rdata[31:16] : wb.i_mem_rdata[15:0];
    case (ld_funct3_q)
      3'd0:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'd4:    load_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'd5:    load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = wb.i_mem_rdata;
    endcase
  end

  always_comb begin
    direct_data = wb.i_alu_result;
    if (wb.i_wb_sel == WbLink) begin
      direct_data = wb.i_pc + XLEN'(4);
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    ld_fault_d  = ld_fault_q;
    we_d        = 1'b0;
    rd_addr_d   = rd_addr_q;
    wdata_d     = wdata_q;
    retire_d    = 1'b0;
    fault_d     = 1'b0;

    unique case (state_q)
      StIdle, StCommit: begin
        state_d = StIdle;
        if (accept) begin
          if (wb.i_wb_sel == WbLoad) begin
            state_d     = StWaitMem;
            ld_rd_d     = wb.i_rd;
            ld_funct3_d = wb.i_funct3;
            ld_off_d    = wb.i_alu_result[1:0];
            ld_fault_d  = in_illegal || in_misaligned;
          end else begin
            state_d  = StCommit;
            retire_d = 1'b1;
            we_d     = (wb.i_wb_sel != WbNone) && (wb.i_rd != 5'd0);
            if (we_d) begin
              rd_addr_d = wb.i_rd;
              wdata_d   = direct_data;
            end
          end
        end
      end
      StWaitMem: begin
        if (wb.i_mem_rvalid) begin
          state_d  = StCommit;
          retire_d = 1'b1;
          fault_d  = ld_fault_q;
          we_d     = !ld_fault_q && (ld_rd_q != 5'd0);
          if (we_d) begin
            rd_addr_d = ld_rd_q;
            wdata_d   = load_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      ld_rd_q     <= 5'd0;
      ld_funct3_q <= 3'd0;
      ld_off_q    <= 2'd0;
      ld_fault_q  <= 1'b0;
      we_q        <= 1'b0;
      rd_addr_q   <= 5'd0;
      wdata_q     <= '0;
      retire_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
      ld_fault_q  <= ld_fault_d;
      we_q        <= we_d;
      rd_addr_q   <= rd_addr_d;
      wdata_q     <= wdata_d;
      retire_q    <= retire_d;
      fault_q     <= fault_d;
    end
  end

  assign wb.o_ready        = ready;
  assign wb.o_write_enable = we_q;
  assign wb.o_rd_addr      = rd_addr_q;
  assign wb.o_write_data   = wdata_q;
  assign wb.o_retire       = retire_q;
  assign wb.o_fault        = fault_q;

  logic unused_wb_sel;
  assign unused_wb_sel = (wb.i_wb_sel == WbAlu);

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected commits are queued at issue time and popped
// whenever the stage retires.
module tb_writeback_stage;

  typedef struct {
    logic        we;
    logic        fault;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic i_clk;
  logic i_rst_n;

  writeback_stage_if #(.XLEN(32)) wbif ();

  writeback_stage #(.XLEN(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wb      (wbif.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  exp_t        sb[$];
  logic [4:0]  model_rd   = 5'd0;
  logic [31:0] model_data = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * int'(off))) & 32'hFF;
    h = (rdata >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  // Commit monitor: every retire pops one expectation; no write or fault without a retire.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (wbif.o_retire) begin
        if (sb.size() == 0) begin
          check_eq("spurious_retire", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("we", {31'd0, wbif.o_write_enable}, {31'd0, e.we});
          check_eq("fault", {31'd0, wbif.o_fault}, {31'd0, e.fault});
          check_eq("rd_addr", {27'd0, wbif.o_rd_addr}, {27'd0, e.rd});
          check_eq("wdata", wbif.o_write_data, e.data);
        end
      end else begin
        check_eq("idle_we", {31'd0, wbif.o_write_enable}, 32'd0);
        check_eq("idle_fault", {31'd0, wbif.o_fault}, 32'd0);
      end
    end
  end

  task automatic idle_cycle();
    wbif.i_valid = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  // Issue one instruction; loads get their response dly cycles after acceptance.
  task automatic send(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] pc, input int dly,
                      input logic [31:0] rdata);
    exp_t        e;
    logic [31:0] d;
    logic        illegal;
    logic        misal;
    e.fault = 1'b0;
    d       = alu;
    if (sel == 2'd1) begin
      illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      misal   = (((f3 == 3'd1) || (f3 == 3'd5)) && alu[0]) || ((f3 == 3'd2) && (alu[1:0] != 0));
      e.fault = illegal || misal;
      d       = load_model(f3, alu[1:0], rdata);
    end else if (sel == 2'd2) begin
      d = pc + 32'd4;
    end
    e.we = (sel != 2'd3) && (rd != 5'd0) && !e.fault;
    if (e.we) begin
      model_rd   = rd;
      model_data = d;
    end
    e.rd   = model_rd;
    e.data = model_data;
    sb.push_back(e);

    check_eq("ready_accept", {31'd0, wbif.o_ready}, 32'd1);
    wbif.i_valid      = 1'b1;
    wbif.i_rd         = rd;
    wbif.i_wb_sel     = sel;
    wbif.i_funct3     = f3;
    wbif.i_alu_result = alu;
    wbif.i_pc         = pc;
    @(posedge i_clk);
    #1;
    wbif.i_valid = 1'b0;
    if (sel == 2'd1) begin
      for (int i = 0; i < dly; i++) begin
        check_eq("ready_wait", {31'd0, wbif.o_ready}, 32'd0);
        @(posedge i_clk);
        #1;
      end
      wbif.i_mem_rvalid = 1'b1;
      wbif.i_mem_rdata  = rdata;
      @(posedge i_clk);
      #1;
      wbif.i_mem_rvalid = 1'b0;
      wbif.i_mem_rdata  = $urandom;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, {31'd0, wbif.o_write_enable}, 32'd0);
    check_eq({tag, "_retire"}, {31'd0, wbif.o_retire}, 32'd0);
    check_eq({tag, "_fault"}, {31'd0, wbif.o_fault}, 32'd0);
    check_eq({tag, "_rd_addr"}, {27'd0, wbif.o_rd_addr}, 32'd0);
    check_eq({tag, "_wdata"}, wbif.o_write_data, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, wbif.o_ready}, 32'd1);
  endtask

  initial begin
    i_rst_n           = 1'b0;
    wbif.i_valid      = 1'b0;
    wbif.i_rd         = 5'd0;
    wbif.i_wb_sel     = 2'd0;
    wbif.i_funct3     = 3'd0;
    wbif.i_alu_result = 32'd0;
    wbif.i_pc         = 32'd0;
    wbif.i_mem_rvalid = 1'b0;
    wbif.i_mem_rdata  = 32'd0;
    #12;
    check_reset_outputs("reset");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle_cycle();

    // ALU, then one quiet cycle
    send(5'd3, 2'd0, 3'd0, 32'h0000_04D2, 32'h0, 0, 32'h0);
    idle_cycle();
    check_eq("alu_after_retire", {31'd0, wbif.o_retire}, 32'd0);

    // Link, including wrap-around
    send(5'd1, 2'd2, 3'd0, 32'h0, 32'h0000_0100, 0, 32'h0);
    send(5'd1, 2'd2, 3'd0, 32'h0, 32'hFFFF_FFFC, 0, 32'h0);
    idle_cycle();

    // Loads with extension
    send(5'd5, 2'd1, 3'd0, 32'h0000_1002, 32'h0, 3, 32'h12F4_5678);
    send(5'd6, 2'd1, 3'd4, 32'h0000_1002, 32'h0, 3, 32'h12F4_5678);
    send(5'd7, 2'd1, 3'd5, 32'h0000_1002, 32'h0, 1, 32'h12F4_5678);
    send(5'd8, 2'd1, 3'd1, 32'h0000_1000, 32'h0, 0, 32'h12F4_5678);
    send(5'd9, 2'd1, 3'd1, 32'h0000_1002, 32'h0, 2, 32'h80F4_5678);
    send(5'd10, 2'd1, 3'd0, 32'h0000_1003, 32'h0, 1, 32'h80F4_5678);
    send(5'd11, 2'd1, 3'd2, 32'h0000_1000, 32'h0, 2, 32'hCAFE_F00D);
    idle_cycle();

    // Faults: misaligned lh, illegal funct3, misaligned lw
    send(5'd12, 2'd1, 3'd1, 32'h0000_1001, 32'h0, 2, 32'h1111_2222);
    send(5'd13, 2'd1, 3'd3, 32'h0000_1000, 32'h0, 1, 32'h3333_4444);
    send(5'd14, 2'd1, 3'd2, 32'h0000_1002, 32'h0, 0, 32'h5555_6666);
    idle_cycle();

    // x0 and no-write, then three back-to-back ALU ops
    send(5'd0, 2'd0, 3'd0, 32'h0000_DEAD, 32'h0, 0, 32'h0);
    send(5'd15, 2'd3, 3'd0, 32'h1234_5678, 32'h0, 0, 32'h0);
    send(5'd0, 2'd1, 3'd2, 32'h0000_2000, 32'h0, 1, 32'h7777_8888);
    send(5'd16, 2'd0, 3'd0, 32'hA000_0001, 32'h0, 0, 32'h0);
    send(5'd17, 2'd0, 3'd0, 32'hA000_0002, 32'h0, 0, 32'h0);
    send(5'd18, 2'd0, 3'd0, 32'hA000_0003, 32'h0, 0, 32'h0);
    idle_cycle();

    // Response strobes outside WAIT_MEM are ignored
    wbif.i_mem_rvalid = 1'b1;
    wbif.i_mem_rdata  = 32'hBAD0_BAD0;
    idle_cycle();
    idle_cycle();
    wbif.i_mem_rvalid = 1'b0;

    // Reset while waiting on memory drops the load
    check_eq("ready_pre_rst", {31'd0, wbif.o_ready}, 32'd1);
    wbif.i_valid      = 1'b1;
    wbif.i_rd         = 5'd20;
    wbif.i_wb_sel     = 2'd1;
    wbif.i_funct3     = 3'd2;
    wbif.i_alu_result = 32'h0000_3000;
    @(posedge i_clk);
    #1;
    wbif.i_valid = 1'b0;
    idle_cycle();
    check_eq("ready_before_rst", {31'd0, wbif.o_ready}, 32'd0);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    model_rd   = 5'd0;
    model_data = 32'd0;
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    wbif.i_mem_rvalid = 1'b1;
    wbif.i_mem_rdata  = 32'h9999_AAAA;
    @(posedge i_clk);
    #1;
    wbif.i_mem_rvalid = 1'b0;
    check_reset_outputs("rst_after");

    // Recovers normally after reset
    send(5'd21, 2'd0, 3'd0, 32'h0BAD_CAFE, 32'h0, 0, 32'h0);
    idle_cycle();
    idle_cycle();
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
